// File: rtl/mmio_wr_fifo_pkg.sv
// Shared register map, status-word layout and control-bit positions for the
// MMIO write FIFO. Optional dropped-push counter: MMIO_WR_FIFO_OVF_CNT_EN.
package mmio_wr_fifo_pkg;

    // Register map
    localparam logic [15:0] ADDR_PUSH   = 16'h0020;
    localparam logic [15:0] ADDR_POP    = 16'h0022;
    localparam logic [15:0] ADDR_STATUS = 16'h0024;
    localparam logic [15:0] ADDR_OVFCNT = 16'h0026;
    localparam logic [15:0] ADDR_CTRL   = 16'h0028;

    // Status word layout
    localparam int ST_FULL_BIT  = 63;
    localparam int ST_EMPTY_BIT = 62;
    localparam int ST_OVF_BIT   = 61;
    localparam int ST_UNF_BIT   = 60;
    localparam int ST_COUNT_LSB = 0;
    localparam int ST_COUNT_W   = 16;

    // Control register bits
    localparam int CTRL_FLUSH_BIT = 0;
    localparam int CTRL_CLR_BIT   = 1;

    typedef enum logic [2:0] {
        REG_PUSH,
        REG_POP,
        REG_STATUS,
        REG_OVFCNT,
        REG_CTRL,
        REG_NONE
    } reg_sel_e;

    // Map an MMIO address onto the register it selects
    function automatic reg_sel_e decode_addr(input logic [15:0] addr);
        reg_sel_e sel;
        case (addr)
            ADDR_PUSH:   sel = REG_PUSH;
            ADDR_POP:    sel = REG_POP;
            ADDR_STATUS: sel = REG_STATUS;
            ADDR_OVFCNT: sel = REG_OVFCNT;
            ADDR_CTRL:   sel = REG_CTRL;
            default:     sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mmio_wr_fifo_mem.sv
// FIFO storage: DEPTH x DATA_W array, synchronous write, combinational read.
// Contents are deliberately not reset.
module mmio_wr_fifo_mem #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mmio_wr_fifo.sv
// MMIO-mapped write FIFO: pushes at PUSH, pops/status/counter reads return a
// registered response one clock after the read strobe.
// Optional feature macro: MMIO_WR_FIFO_OVF_CNT_EN (32-bit saturating count of
// dropped pushes, readable at OVFCNT).
module mmio_wr_fifo
    import mmio_wr_fifo_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [15:0]       wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    input  logic [15:0]       rd_addr,
    input  logic [8:0]        rd_tid,
    output logic              resp_valid,
    output logic [8:0]        resp_tid,
    output logic [63:0]       resp_data,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              resp_valid_q, resp_valid_d;
    logic [8:0]        resp_tid_q, resp_tid_d;
    logic [63:0]       resp_data_q, resp_data_d;

    logic              mem_we;
    logic [DATA_W-1:0] mem_rd_data;
    logic [63:0]       head_word;
    logic [63:0]       status_word;
    logic [63:0]       ovfcnt_word;

    reg_sel_e          wr_sel;
    reg_sel_e          rd_sel;
    logic              push_req;
    logic              pop_req;
    logic              ctrl_wr;

    assign wr_sel   = decode_addr(wr_addr);
    assign rd_sel   = decode_addr(rd_addr);
    assign push_req = wr_valid && (wr_sel == REG_PUSH);
    assign pop_req  = rd_valid && (rd_sel == REG_POP);
    assign ctrl_wr  = wr_valid && (wr_sel == REG_CTRL);

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    mmio_wr_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rd_data)
    );

    // Fit the stored entry onto the 64-bit response bus
    generate
        if (DATA_W >= 64) begin : g_head_trunc
            assign head_word = mem_rd_data[63:0];
        end else begin : g_head_ext
            assign head_word = {{(64 - DATA_W){1'b0}}, mem_rd_data};
        end
    endgenerate

    // Status word assembled from the pre-update registered state
    always_comb begin
        status_word = '0;
        status_word[ST_FULL_BIT]  = full;
        status_word[ST_EMPTY_BIT] = empty;
        status_word[ST_OVF_BIT]   = ovf_q;
        status_word[ST_UNF_BIT]   = unf_q;
        status_word[ST_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(count_q);
    end

`ifdef MMIO_WR_FIFO_OVF_CNT_EN
    logic [31:0] ovf_cnt_q, ovf_cnt_d;

    // Dropped-push counter: saturates, cleared by the CTRL clear bit
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (push_req && !pop_req && full && (ovf_cnt_q != '1)) begin
            ovf_cnt_d = ovf_cnt_q + 32'd1;
        end
        if (ctrl_wr && wr_data[CTRL_CLR_BIT]) begin
            ovf_cnt_d = '0;
        end
    end

    // Dropped-push counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovfcnt_word = {32'b0, ovf_cnt_q};
`else
    assign ovfcnt_word = '0;
`endif

    // Next-state for pointers, count, sticky flags and the read response.
    // A simultaneous push and pop always advances both pointers with count
    // held; on an empty FIFO that means the pushed entry is written and
    // consumed in the same step while the pop itself reports underflow.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        ovf_d        = ovf_q;
        unf_d        = unf_q;
        mem_we       = 1'b0;
        resp_valid_d = rd_valid;
        resp_tid_d   = rd_tid;
        resp_data_d  = '0;

        if (push_req && pop_req) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (empty) begin
                unf_d = 1'b1;
            end
        end else if (push_req) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                count_d  = count_q + 1'b1;
            end
        end else if (pop_req) begin
            if (empty) begin
                unf_d = 1'b1;
            end else begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                count_d  = count_q - 1'b1;
            end
        end

        // Control writes dominate the same cycle's pointer/flag updates
        if (ctrl_wr) begin
            if (wr_data[CTRL_FLUSH_BIT]) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                count_d  = '0;
            end
            if (wr_data[CTRL_CLR_BIT]) begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
            end
        end

        if (rd_valid) begin
            case (rd_sel)
                REG_POP:    resp_data_d = empty ? 64'd0 : head_word;
                REG_STATUS: resp_data_d = status_word;
                REG_OVFCNT: resp_data_d = ovfcnt_word;
                default:    resp_data_d = '0;
            endcase
        end
    end

    // State and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_tid_q   <= '0;
            resp_data_q  <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
            resp_valid_q <= resp_valid_d;
            resp_tid_q   <= resp_tid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    // A reset arriving while a response is on the bus withdraws it at once
    assign resp_valid = resp_valid_q && !rst;
    assign resp_tid   = rst ? 9'd0  : resp_tid_q;
    assign resp_data  = rst ? 64'd0 : resp_data_q;

endmodule

// File: tb/tb_mmio_wr_fifo.sv
// Self-checking bench for mmio_wr_fifo: directed scenarios followed by a
// randomized phase, all compared against a queue-based reference model.
module tb_mmio_wr_fifo;

    localparam int DEPTH = 8;
    localparam logic [15:0] A_PUSH   = 16'h0020;
    localparam logic [15:0] A_POP    = 16'h0022;
    localparam logic [15:0] A_STATUS = 16'h0024;
    localparam logic [15:0] A_OVFCNT = 16'h0026;
    localparam logic [15:0] A_CTRL   = 16'h0028;
    localparam logic [15:0] A_NONE   = 16'h0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic [15:0] wr_addr;
    logic [63:0] wr_data;
    logic        rd_valid;
    logic [15:0] rd_addr;
    logic [8:0]  rd_tid;
    logic        resp_valid;
    logic [8:0]  resp_tid;
    logic [63:0] resp_data;
    logic        full;
    logic        empty;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    logic [63:0] mq[$];
    bit          m_ovf;
    bit          m_unf;
    logic [31:0] m_cnt;

    mmio_wr_fifo #(.DEPTH(DEPTH), .DATA_W(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_valid   (rd_valid),
        .rd_addr    (rd_addr),
        .rd_tid     (rd_tid),
        .resp_valid (resp_valid),
        .resp_tid   (resp_tid),
        .resp_data  (resp_data),
        .full       (full),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [63:0] model_status();
        logic [63:0] st;
        st = '0;
        st[63] = (mq.size() == DEPTH);
        st[62] = (mq.size() == 0);
        st[61] = m_ovf;
        st[60] = m_unf;
        st[15:0] = 16'(mq.size());
        return st;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_cnt = '0;
    endtask

    // One bus cycle: predict, drive, clock, compare
    task automatic cyc(input logic wv, input logic [15:0] wa, input logic [63:0] wd,
                       input logic rv, input logic [15:0] ra);
        logic [8:0]  tid;
        logic [63:0] exp_data;
        bit          push;
        bit          pop;
        tid      = 9'($urandom_range(0, 511));
        exp_data = '0;
        if (rv) begin
            case (ra)
                A_POP:    exp_data = (mq.size() == 0) ? 64'd0 : mq[0];
                A_STATUS: exp_data = model_status();
                A_OVFCNT: begin
`ifdef MMIO_WR_FIFO_OVF_CNT_EN
                    exp_data = {32'b0, m_cnt};
`endif
                end
                default:  exp_data = '0;
            endcase
        end
        push = wv && (wa == A_PUSH);
        pop  = rv && (ra == A_POP);
        if (push && pop) begin
            if (mq.size() == 0) begin
                m_unf = 1'b1;
            end else begin
                void'(mq.pop_front());
                mq.push_back(wd);
            end
        end else if (push) begin
            if (mq.size() == DEPTH) begin
                m_ovf = 1'b1;
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            end else begin
                mq.push_back(wd);
            end
        end else if (pop) begin
            if (mq.size() == 0) m_unf = 1'b1;
            else void'(mq.pop_front());
        end
        if (wv && wa == A_CTRL) begin
            if (wd[0]) mq.delete();
            if (wd[1]) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
                m_cnt = '0;
            end
        end

        wr_valid = wv; wr_addr = wa; wr_data = wd;
        rd_valid = rv; rd_addr = ra; rd_tid = tid;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        $display("cyc wv=%0b wa=%h wd=%h rv=%0b ra=%h tid=%0d -> resp_valid=%0b data=%h",
                 wv, wa, wd, rv, ra, tid, resp_valid, resp_data);
        chk("resp_valid", 64'(resp_valid), 64'(rv));
        if (rv) begin
            chk("resp_tid", 64'(resp_tid), 64'(tid));
            chk("resp_data", resp_data, exp_data);
        end
        chk("full",  64'(full),  64'(mq.size() == DEPTH));
        chk("empty", 64'(empty), 64'(mq.size() == 0));
    endtask

    task automatic push(input logic [63:0] d);   cyc(1'b1, A_PUSH, d, 1'b0, A_NONE);    endtask
    task automatic pop();                         cyc(1'b0, A_NONE, 0, 1'b1, A_POP);     endtask
    task automatic status();                      cyc(1'b0, A_NONE, 0, 1'b1, A_STATUS);  endtask
    task automatic ctrl(input logic [63:0] d);   cyc(1'b1, A_CTRL, d, 1'b0, A_NONE);    endtask
    task automatic pushpop(input logic [63:0] d); cyc(1'b1, A_PUSH, d, 1'b1, A_POP);     endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        $display("reset applied");
    endtask

    initial begin
        logic        wv;
        logic        rv;
        logic [15:0] wa;
        logic [15:0] ra;
        logic [63:0] wd;

        rst = 1'b1; wr_valid = 0; wr_addr = 0; wr_data = 0;
        rd_valid = 0; rd_addr = 0; rd_tid = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_tid", 64'(resp_tid), 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);

        // In-order push/pop
        push(64'h11); push(64'h22); push(64'h33);
        pop(); pop(); pop();
        status();

        // Overflow: nine pushes into eight entries
        for (int i = 0; i < 9; i++) push(64'h100 + 64'(i));
        status();
        cyc(1'b0, A_NONE, 0, 1'b1, A_OVFCNT);
        for (int i = 0; i < 8; i++) pop();

        // Underflow and sticky clear
        pop();
        status();
        ctrl(64'h2);
        status();
        cyc(1'b0, A_NONE, 0, 1'b1, A_OVFCNT);

        // Same-cycle push/pop while full
        for (int i = 0; i < 8; i++) push(64'h200 + 64'(i));
        pushpop(64'hAA);
        status();
        for (int i = 0; i < 8; i++) pop();

        // Same-cycle push/pop while empty
        pushpop(64'hBB);
        status();
        ctrl(64'h2);

        // Flush
        push(64'h1); push(64'h2); push(64'h3);
        ctrl(64'h1);
        status();

        // Unmapped accesses
        cyc(1'b1, A_NONE, 64'hDEAD, 1'b1, A_NONE);
        status();

        // Reset the cycle after a read suppresses its response
        rd_valid = 1'b1; rd_addr = A_STATUS; rd_tid = 9'd5;
        @(posedge clk);
        #1;
        rd_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_suppress_now", 64'(resp_valid), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk("rst_suppress_after", 64'(resp_valid), 64'd0);
        chk("rst_suppress_tid", 64'(resp_tid), 64'd0);

        // Pointer wrap with steady-state push/pop
        for (int i = 0; i < 5; i++) push(64'h300 + 64'(i));
        for (int i = 0; i < 20; i++) pushpop(64'h400 + 64'(i));
        while (mq.size() != 0) pop();
        do_reset();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            wv = 1'($urandom_range(0, 1));
            rv = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       begin wa = A_CTRL; wd = 64'($urandom_range(0, 3)); end
                1:       begin wa = A_NONE; wd = {$urandom, $urandom}; end
                default: begin wa = A_PUSH; wd = {$urandom, $urandom}; end
            endcase
            case ($urandom_range(0, 7))
                0:       ra = A_STATUS;
                1:       ra = A_OVFCNT;
                2:       ra = A_NONE;
                default: ra = A_POP;
            endcase
            if (wa == A_CTRL && wd[0] && $urandom_range(0, 3) != 0) wd[0] = 1'b0;
            cyc(wv, wa, wd, rv, ra);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mmio_wr_fifo.md
MMIO_WR_FIFO -- requirements
Module: mmio_wr_fifo

Interface
REQ-001 Parameters SHALL be as follows.
- DEPTH, default 8, number of entries; power of two, at least 2.
- DATA_W, default 64, width of a data entry.
REQ-002 Ports SHALL be as follows.
- clk, input, 1, the single clock.
- rst, input, 1, synchronous active-high reset.
REQ-003 Write-side ports SHALL be as follows.
- wr_valid, input, 1, MMIO write strobe.
- wr_addr, input, 16, MMIO write address.
- wr_data, input, DATA_W, MMIO write data.
REQ-004 Read-side ports SHALL be as follows.
- rd_valid, input, 1, MMIO read strobe.
- rd_addr, input, 16, MMIO read address.
- rd_tid, input, 9, read transaction ID.
REQ-005 Response ports SHALL be as follows.
- resp_valid, output, 1, read response strobe.
- resp_tid, output, 9, echo of rd_tid.
- resp_data, output, 64, read response data.
REQ-006 Occupancy ports SHALL be as follows.
- full, output, 1, FIFO holds DEPTH entries.
- empty, output, 1, FIFO holds no entries.

Function
REQ-007 A write with wr_valid=1 and wr_addr=16'h0020 SHALL push wr_data when the FIFO is not full.
REQ-008 A push while full SHALL be dropped, leave contents unchanged, and set the sticky ovf flag.
REQ-009 A read with rd_valid=1 and rd_addr=16'h0022 SHALL return the head entry and pop it when the FIFO is not empty.
REQ-010 A pop read while empty SHALL return 0 and set the sticky unf flag.
REQ-011 A read at 16'h0024 SHALL return the status word: bit 63 full, bit 62 empty, bit 61 ovf, bit 60 unf, bits [15:0] count; all other bits 0.
REQ-012 A write at 16'h0028 SHALL act on wr_data as follows.
- bit 0 flushes the FIFO: pointers and count go to 0.
- bit 1 clears ovf and unf.
- both bits SHALL take effect in the same cycle.
REQ-013 Every read SHALL produce resp_valid=1 for exactly one cycle, one clk after rd_valid, with resp_tid equal to the rd_tid of that read.
REQ-014 Reads at unmapped addresses SHALL return 0.
REQ-015 Writes at unmapped addresses SHALL be ignored.
REQ-016 A push and a pop in the same cycle SHALL both take effect with count unchanged, including when the FIFO is full or empty.
- When full, the push SHALL be accepted and ovf SHALL NOT be set.
- When empty, the pop SHALL return 0 and unf SHALL be set; the push SHALL land.
REQ-017 Pop data SHALL be the head entry before that cycle's push.
REQ-018 Read and write pointers SHALL wrap modulo DEPTH.
REQ-019 count SHALL be $clog2(DEPTH)+1 bits wide, range 0..DEPTH, and be zero-extended into the status word.
REQ-020 full SHALL equal (count==DEPTH) and empty SHALL equal (count==0), both driven combinationally from registered state.
REQ-021 When a status read coincides with a push or pop, the status word SHALL reflect the state before that cycle's update.

Reset
REQ-022 While rst=1 at a clk edge, the following SHALL be cleared: pointers, count, ovf, unf, resp_valid, resp_tid, resp_data.
REQ-023 Memory contents SHALL NOT be reset.
REQ-024 A rst asserted in the cycle after a read SHALL suppress that read's pending response.
REQ-025 After reset, outputs SHALL be: empty=1, full=0, resp_valid=0, resp_tid=0, resp_data=0.

Configuration
REQ-026 With MMIO_WR_FIFO_OVF_CNT_EN defined, the block SHALL provide a 32-bit saturating count of dropped pushes.
- The count SHALL be readable at 16'h0026 in bits [31:0].
- It SHALL be cleared by rst and by wr_data bit 1 of a write at 16'h0028.
REQ-027 Without MMIO_WR_FIFO_OVF_CNT_EN, no counter logic SHALL exist and a read at 16'h0026 SHALL return 0.

Structure
REQ-028 Package mmio_wr_fifo_pkg SHALL hold the following.
- Address constants PUSH 16'h0020, POP 16'h0022, STATUS 16'h0024, OVFCNT 16'h0026, CTRL 16'h0028.
- Status-word bit positions.
- The CTRL bit positions.
REQ-029 Storage SHALL be a sub-module mmio_wr_fifo_mem: DEPTH x DATA_W, one synchronous write port and one combinational read port.
REQ-030 Pointer, count and flag logic and the response register SHALL reside in mmio_wr_fifo.

Verification
REQ-031 Push 0x11,0x22,0x33, then pop three times -> responses 0x11,0x22,0x33 with matching tids, each one cycle after its read; empty=1 at the end.
REQ-032 Push 9 values with DEPTH=8 -> status read returns bit63=1, bit61=1, count=8; the ninth value is absent from pops; the counter reads 1 when the macro is defined.
REQ-033 Pop while empty -> resp_data=0 and status bit60=1; CTRL write 0x2 -> both stickies are 0.
REQ-034 Fill to 8, then a same-cycle push 0xAA and pop -> pop returns the oldest value, count stays 8, ovf=0; 0xAA is popped last.
REQ-035 Push 3 values, CTRL write 0x1 -> status returns empty=1, count=0.
REQ-036 Assert rst the cycle after a read -> no resp_valid; 20 push/pop cycles around the pointer wrap -> data order preserved.
